// File: rtl/score_uart_tx.sv
// Game-status UART transmitter: converts an 8-bit score to "S:HTO\r\n" and
// sends "GO\r\n" on a gameover rising edge, one byte per txclk strobe.
module score_uart_tx #(
  parameter int unsigned GAP_CYCLES = 1,
  parameter int unsigned TIMEOUT    = 200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] score,
  input  logic       send_req,
  input  logic       gameover,
  input  logic       txready,
  output logic [7:0] txdata,
  output logic       txclk,
  output logic       busy,
  output logic       tx_err
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CONV   = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_STROBE = 3'd3;
  localparam logic [2:0] S_GAP    = 3'd4;

  localparam int unsigned WCW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned GCW = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT - 1);
  localparam logic [GCW-1:0] GAP_LAST  = GCW'(GAP_CYCLES - 1);

  logic [2:0]     r_state,      w_state_nx;
  logic           r_go_q;
  logic           r_go_pend,    w_go_pend_nx;
  logic           r_score_pend, w_score_pend_nx;
  logic [7:0]     r_score,      w_score_nx;
  logic [7:0]     r_v,          w_v_nx;
  logic [3:0]     r_hund,       w_hund_nx;
  logic [3:0]     r_tens,       w_tens_nx;
  logic [3:0]     r_ones,       w_ones_nx;
  logic           r_is_go,      w_is_go_nx;
  logic [2:0]     r_idx,        w_idx_nx;
  logic [WCW-1:0] r_wait_cnt,   w_wait_cnt_nx;
  logic [GCW-1:0] r_gap_cnt,    w_gap_cnt_nx;
  logic [7:0]     r_txdata,     w_txdata_nx;
  logic           r_txclk,      w_txclk_nx;
  logic           r_busy,       w_busy_nx;
  logic           r_tx_err,     w_tx_err_nx;

  logic           w_go_edge;
  logic [7:0]     w_byte;
  logic           w_last;

  assign txdata = r_txdata;
  assign txclk  = r_txclk;
  assign busy   = r_busy;
  assign tx_err = r_tx_err;

  assign w_go_edge = gameover & ~r_go_q;

  // Current frame byte selected by frame type and byte index
  always_comb begin
    w_byte = 8'h00;
    if (r_is_go) begin
      case (r_idx)
        3'd0:    w_byte = 8'h47;
        3'd1:    w_byte = 8'h4F;
        3'd2:    w_byte = 8'h0D;
        default: w_byte = 8'h0A;
      endcase
    end else begin
      case (r_idx)
        3'd0:    w_byte = 8'h53;
        3'd1:    w_byte = 8'h3A;
        3'd2:    w_byte = 8'h30 + {4'h0, r_hund};
        3'd3:    w_byte = 8'h30 + {4'h0, r_tens};
        3'd4:    w_byte = 8'h30 + {4'h0, r_ones};
        3'd5:    w_byte = 8'h0D;
        default: w_byte = 8'h0A;
      endcase
    end
  end

  assign w_last = r_is_go ? (r_idx == 3'd3) : (r_idx == 3'd6);

  // Next-state and registered-output logic
  always_comb begin
    w_state_nx      = r_state;
    w_go_pend_nx    = r_go_pend | w_go_edge;
    w_score_pend_nx = r_score_pend | send_req;
    w_score_nx      = send_req ? score : r_score;
    w_v_nx          = r_v;
    w_hund_nx       = r_hund;
    w_tens_nx       = r_tens;
    w_ones_nx       = r_ones;
    w_is_go_nx      = r_is_go;
    w_idx_nx        = r_idx;
    w_wait_cnt_nx   = r_wait_cnt;
    w_gap_cnt_nx    = r_gap_cnt;
    w_txdata_nx     = r_txdata;
    w_txclk_nx      = 1'b0;
    w_tx_err_nx     = r_tx_err;

    case (r_state)
      S_IDLE: begin
        // GO frame wins; a simultaneous score request stays pending
        if (w_go_pend_nx) begin
          w_go_pend_nx  = 1'b0;
          w_is_go_nx    = 1'b1;
          w_idx_nx      = 3'd0;
          w_wait_cnt_nx = '0;
          w_state_nx    = S_WAIT;
        end else if (w_score_pend_nx) begin
          w_score_pend_nx = 1'b0;
          w_is_go_nx      = 1'b0;
          w_idx_nx        = 3'd0;
          w_v_nx          = w_score_nx;
          w_hund_nx       = 4'd0;
          w_tens_nx       = 4'd0;
          w_ones_nx       = 4'd0;
          w_state_nx      = S_CONV;
        end
      end
      S_CONV: begin
        if (r_v >= 8'd100) begin
          w_v_nx    = r_v - 8'd100;
          w_hund_nx = r_hund + 4'd1;
        end else if (r_v >= 8'd10) begin
          w_v_nx    = r_v - 8'd10;
          w_tens_nx = r_tens + 4'd1;
        end else begin
          w_ones_nx     = r_v[3:0];
          w_wait_cnt_nx = '0;
          w_state_nx    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (txready) begin
          w_txdata_nx = w_byte;
          w_txclk_nx  = 1'b1;
          w_state_nx  = S_STROBE;
        end else if ((TIMEOUT != 0) && (r_wait_cnt == WAIT_LAST)) begin
          w_tx_err_nx = 1'b1;
          w_txdata_nx = 8'h00;
          w_state_nx  = S_IDLE;
        end else begin
          w_wait_cnt_nx = r_wait_cnt + WCW'(1);
        end
      end
      S_STROBE: begin
        w_gap_cnt_nx = '0;
        w_state_nx   = S_GAP;
      end
      S_GAP: begin
        if (r_gap_cnt == GAP_LAST) begin
          w_idx_nx      = r_idx + 3'd1;
          w_wait_cnt_nx = '0;
          w_state_nx    = w_last ? S_IDLE : S_WAIT;
        end else begin
          w_gap_cnt_nx = r_gap_cnt + GCW'(1);
        end
      end
      default: w_state_nx = S_IDLE;
    endcase

    w_busy_nx = (w_state_nx != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_go_q       <= 1'b0;
      r_go_pend    <= 1'b0;
      r_score_pend <= 1'b0;
      r_score      <= 8'h00;
      r_v          <= 8'h00;
      r_hund       <= 4'd0;
      r_tens       <= 4'd0;
      r_ones       <= 4'd0;
      r_is_go      <= 1'b0;
      r_idx        <= 3'd0;
      r_wait_cnt   <= '0;
      r_gap_cnt    <= '0;
      r_txdata     <= 8'h00;
      r_txclk      <= 1'b0;
      r_busy       <= 1'b0;
      r_tx_err     <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_go_q       <= gameover;
      r_go_pend    <= w_go_pend_nx;
      r_score_pend <= w_score_pend_nx;
      r_score      <= w_score_nx;
      r_v          <= w_v_nx;
      r_hund       <= w_hund_nx;
      r_tens       <= w_tens_nx;
      r_ones       <= w_ones_nx;
      r_is_go      <= w_is_go_nx;
      r_idx        <= w_idx_nx;
      r_wait_cnt   <= w_wait_cnt_nx;
      r_gap_cnt    <= w_gap_cnt_nx;
      r_txdata     <= w_txdata_nx;
      r_txclk      <= w_txclk_nx;
      r_busy       <= w_busy_nx;
      r_tx_err     <= w_tx_err_nx;
    end
  end

endmodule

// File: tb/tb_score_uart_tx.sv
// Bench for score_uart_tx: frames are predicted from score arithmetic and
// compared byte-by-byte against what the DUT strobes out.
module tb_score_uart_tx;

  localparam int GAP = 1;
  localparam int TMO = 200;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] score = 8'h00;
  logic       send_req = 1'b0;
  logic       gameover = 1'b0;
  logic       txready = 1'b1;
  logic [7:0] txdata;
  logic       txclk;
  logic       busy;
  logic       tx_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int req_cyc = 0;
  int tr_mode = 1;
  int dbl = 0;
  logic prev_txclk = 1'b0;

  logic [7:0] obs_q[$];
  logic [7:0] exp_q[$];
  int         stb_q[$];

  score_uart_tx #(.GAP_CYCLES(GAP), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .score(score), .send_req(send_req),
    .gameover(gameover), .txready(txready), .txdata(txdata),
    .txclk(txclk), .busy(busy), .tx_err(tx_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Byte capture, strobe-width monitor and txready driver
  always @(negedge clk) begin
    if (rst_n && txclk) begin
      obs_q.push_back(txdata);
      stb_q.push_back(cyc);
    end
    if (txclk && prev_txclk) dbl++;
    prev_txclk = txclk;
    case (tr_mode)
      0:       txready = 1'b0;
      1:       txready = 1'b1;
      default: txready = ($urandom_range(0, 3) != 0);
    endcase
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function automatic void add_score_frame(input int s);
    exp_q.push_back(8'h53);
    exp_q.push_back(8'h3A);
    exp_q.push_back(8'(8'h30 + s / 100));
    exp_q.push_back(8'(8'h30 + (s / 10) % 10));
    exp_q.push_back(8'(8'h30 + s % 10));
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endfunction

  function automatic void add_go_frame();
    exp_q.push_back(8'h47);
    exp_q.push_back(8'h4F);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endfunction

  function automatic int conv_cycles(input int s);
    return s / 100 + (s % 100) / 10 + 1;
  endfunction

  function automatic void clear_q();
    obs_q.delete();
    exp_q.delete();
    stb_q.delete();
  endfunction

  task automatic send(input logic [7:0] s);
    @(negedge clk);
    score    = s;
    send_req = 1'b1;
    req_cyc  = cyc + 1;
    @(negedge clk);
    send_req = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    int quiet = 0;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!busy) quiet++; else quiet = 0;
      if (quiet >= 6) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    tr_mode = 1;
    repeat (3) @(negedge clk);
    checks++; if (txdata !== 8'h00) begin errors++; $display("FAIL reset_txdata: got %h expected 00", txdata); end
    checks++; if (txclk !== 1'b0) begin errors++; $display("FAIL reset_txclk: got %b expected 0", txclk); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (tx_err !== 1'b0) begin errors++; $display("FAIL reset_tx_err: got %b expected 0", tx_err); end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0 || txclk !== 1'b0) begin errors++; $display("FAIL post_reset_idle: busy=%b txclk=%b expected 0 0", busy, txclk); end
  endtask

  task automatic test_frame_123();
    bit ok;
    clear_q();
    add_score_frame(123);
    send(8'd123);
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL f123_idle: busy never dropped"); end
    checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL f123_len: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL f123_byte%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
    for (int i = 1; i < stb_q.size(); i++) begin
      checks++; if (stb_q[i] - stb_q[i-1] !== 2 + GAP) begin errors++; $display("FAIL f123_period%0d: got %0d expected %0d", i, stb_q[i] - stb_q[i-1], 2 + GAP); end
    end
  endtask

  task automatic test_conv_latency();
    int s;
    bit ok;
    int vals[5];
    vals[0] = 0;
    vals[1] = 255;
    vals[2] = int'($urandom_range(0, 255));
    vals[3] = int'($urandom_range(100, 199));
    vals[4] = int'($urandom_range(0, 9));
    for (int k = 0; k < 5; k++) begin
      s = vals[k];
      clear_q();
      add_score_frame(s);
      send(8'(s));
      wait_idle(ok);
      checks++; if (!ok || stb_q.size() == 0) begin errors++; $display("FAIL lat_%0d_nostrobe: strobes=%0d expected 7", s, stb_q.size()); end
      else begin
        checks++; if (stb_q[0] !== req_cyc + conv_cycles(s) + 1) begin errors++; $display("FAIL lat_%0d: first strobe at +%0d expected +%0d", s, stb_q[0] - req_cyc, conv_cycles(s) + 1); end
      end
      checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL lat_%0d_len: got %0d expected %0d", s, obs_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
        checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL lat_%0d_byte%0d: got %h expected %h", s, i, obs_q[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_random_frames();
    int s;
    bit ok;
    clear_q();
    tr_mode = 2;
    for (int k = 0; k < 6; k++) begin
      s = int'($urandom_range(0, 255));
      add_score_frame(s);
      send(8'(s));
      wait_idle(ok);
      checks++; if (!ok) begin errors++; $display("FAIL rand_idle%0d: busy never dropped", k); end
    end
    tr_mode = 1;
    checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL rand_len: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_byte%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_coalesce();
    bit ok;
    clear_q();
    tr_mode = 1;
    add_score_frame(100);
    add_score_frame(9);
    send(8'd100);
    repeat (5) @(negedge clk);
    send(8'd5);
    repeat (3) @(negedge clk);
    send(8'd9);
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL coal_idle: busy never dropped"); end
    checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL coal_len: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL coal_byte%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_gameover();
    bit ok;
    clear_q();
    add_go_frame();
    add_score_frame(42);
    @(negedge clk);
    score    = 8'd42;
    send_req = 1'b1;
    gameover = 1'b1;
    @(negedge clk);
    send_req = 1'b0;
    wait_idle(ok);
    // gameover still high: a new score request must not bring a second GO
    add_score_frame(1);
    send(8'd1);
    wait_idle(ok);
    gameover = 1'b0;
    repeat (3) @(negedge clk);
    add_go_frame();
    gameover = 1'b1;
    @(negedge clk);
    wait_idle(ok);
    gameover = 1'b0;
    checks++; if (!ok) begin errors++; $display("FAIL go_idle: busy never dropped"); end
    checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL go_len: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL go_byte%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_timeout();
    bit seen = 1'b0;
    int err_cyc = 0;
    clear_q();
    tr_mode = 0;
    repeat (2) @(negedge clk);
    send(8'd77);
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (tx_err === 1'b1) begin
        seen    = 1'b1;
        err_cyc = cyc;
        break;
      end
    end
    checks++; if (!seen) begin errors++; $display("FAIL tmo_err: tx_err got 0 expected 1"); end
    checks++; if (err_cyc !== req_cyc + conv_cycles(77) + TMO) begin errors++; $display("FAIL tmo_when: got +%0d expected +%0d", err_cyc - req_cyc, conv_cycles(77) + TMO); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL tmo_busy: got %b expected 0", busy); end
    checks++; if (txdata !== 8'h00) begin errors++; $display("FAIL tmo_txdata: got %h expected 00", txdata); end
    tr_mode = 1;
    repeat (30) @(negedge clk);
    checks++; if (obs_q.size() !== 0) begin errors++; $display("FAIL tmo_strobes: got %0d expected 0", obs_q.size()); end
    checks++; if (tx_err !== 1'b1) begin errors++; $display("FAIL tmo_sticky: got %b expected 1", tx_err); end
  endtask

  task automatic test_reset_mid_strobe();
    int seen = 0;
    tr_mode = 1;
    send(8'd200);
    for (int i = 0; i < 200 && seen < 3; i++) begin
      @(negedge clk);
      if (txclk === 1'b1) seen++;
    end
    rst_n = 1'b0;
    #1;
    checks++; if (seen !== 3) begin errors++; $display("FAIL rst_mid_reach: strobes got %0d expected 3", seen); end
    checks++; if (txclk !== 1'b0) begin errors++; $display("FAIL rst_mid_txclk: got %b expected 0", txclk); end
    checks++; if (txdata !== 8'h00) begin errors++; $display("FAIL rst_mid_txdata: got %h expected 00", txdata); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
    checks++; if (tx_err !== 1'b0) begin errors++; $display("FAIL rst_mid_tx_err: got %b expected 0", tx_err); end
    clear_q();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    checks++; if (obs_q.size() !== 0 || busy !== 1'b0) begin errors++; $display("FAIL rst_no_resume: strobes=%0d busy=%b expected 0 0", obs_q.size(), busy); end
  endtask

  task automatic test_strobe_width();
    checks++; if (dbl !== 0) begin errors++; $display("FAIL strobe_width: back-to-back txclk highs got %0d expected 0", dbl); end
  endtask

  initial begin
    test_reset();
    test_frame_123();
    test_conv_latency();
    test_random_frames();
    test_coalesce();
    test_gameover();
    test_timeout();
    test_reset_mid_strobe();
    test_strobe_width();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
